// File: rtl/rate_slot_scheduler_pkg.sv
// Shared constants for the slot scheduler and counter channels.
// Speed codes, default slot loads and FSM state encoding.
package rate_slot_scheduler_pkg;

  localparam logic [1:0] SPD_FAST    = 2'b00;
  localparam logic [1:0] SPD_1HZ     = 2'b01;
  localparam logic [1:0] SPD_HALF    = 2'b10;
  localparam logic [1:0] SPD_QUARTER = 2'b11;

  localparam int DEF_LOAD_1 = 500;
  localparam int DEF_LOAD_2 = 1000;
  localparam int DEF_LOAD_3 = 2000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/rate_slot_scheduler_if.sv
// Request/grant bundle between the channels and the scheduler.
// master = requesting channels, slave = scheduler.
interface rate_slot_scheduler_if #(
  parameter int DIV_WIDTH = 11
);
  logic [3:0]           Req;
  logic [7:0]           Speed;
  logic [3:0]           Grant;
  logic [3:0]           Done;
  logic                 Busy;
  logic [DIV_WIDTH-1:0] Remaining;

  modport master (
    output Req, Speed,
    input  Grant, Done, Busy, Remaining
  );

  modport slave (
    input  Req, Speed,
    output Grant, Done, Busy, Remaining
  );
endinterface

// File: rtl/rate_slot_scheduler_rr_pick4.sv
// Round-robin picker for four requesters.
// Searches last+1, last+2, ... (mod 4) for the first set bit.
module rr_pick4 (
  input  logic [3:0] Req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       valid
);

  logic [1:0] idx;

  // rotate the search start one past the previous winner
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!valid && Req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rate_slot_scheduler.sv
// Shares one slot down-counter between four requesters.
// Round-robin grant, per-slot load from the speed code.
module rate_slot_scheduler
  import rate_slot_scheduler_pkg::*;
#(
  parameter int DIV_WIDTH = 11,
  parameter int LOAD_1    = DEF_LOAD_1,
  parameter int LOAD_2    = DEF_LOAD_2,
  parameter int LOAD_3    = DEF_LOAD_3
) (
  input logic                 ClockIn,
  input logic                 Reset,
  rate_slot_scheduler_if.slave bus
);

  localparam int LIM = 1 << DIV_WIDTH;

  if (LOAD_1 < 1 || LOAD_1 >= LIM ||
      LOAD_2 < 1 || LOAD_2 >= LIM ||
      LOAD_3 < 1 || LOAD_3 >= LIM) begin : g_bad_load
    $error("slot load outside 1 .. 2^DIV_WIDTH-1");
  end

  state_t               state, state_n;
  logic [1:0]           last, last_n;
  logic [3:0]           grant, grant_n;
  logic [3:0]           done, done_n;
  logic [DIV_WIDTH-1:0] remaining, rem_n;
  logic [DIV_WIDTH-1:0] load_m1;
  logic [1:0]           winner;
  logic                 valid;
  logic [1:0]           spd;

  rr_pick4 u_pick (
    .Req    (bus.Req),
    .last   (last),
    .winner (winner),
    .valid  (valid)
  );

  assign spd = bus.Speed[{winner, 1'b0} +: 2];

  // slot length minus one for the winner's speed code
  always_comb begin
    load_m1 = '0;
    unique case (spd)
      SPD_FAST:    load_m1 = '0;
      SPD_1HZ:     load_m1 = DIV_WIDTH'(LOAD_1 - 1);
      SPD_HALF:    load_m1 = DIV_WIDTH'(LOAD_2 - 1);
      SPD_QUARTER: load_m1 = DIV_WIDTH'(LOAD_3 - 1);
      default:     load_m1 = '0;
    endcase
  end

  // next state: grant from idle, abort/expire/decrement while counting
  always_comb begin
    state_n = state;
    last_n  = last;
    grant_n = grant;
    done_n  = '0;
    rem_n   = remaining;
    unique case (state)
      ST_IDLE: begin
        if (valid) begin
          grant_n = 4'b0001 << winner;
          last_n  = winner;
          rem_n   = load_m1;
          state_n = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!bus.Req[last]) begin
          grant_n = '0;
          rem_n   = '0;
          state_n = ST_IDLE;
        end else if (remaining == '0) begin
          done_n[last] = 1'b1;
          grant_n      = '0;
          state_n      = ST_IDLE;
        end else begin
          rem_n = remaining - DIV_WIDTH'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state and output registers; reset aborts any slot silently
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      last      <= 2'd3;
      grant     <= '0;
      done      <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      grant     <= grant_n;
      done      <= done_n;
      remaining <= rem_n;
    end
  end

  assign bus.Grant     = grant;
  assign bus.Done      = done;
  assign bus.Busy      = (state == ST_COUNT);
  assign bus.Remaining = remaining;

endmodule

// File: tb/tb_rate_slot_scheduler.sv
// Bench for rate_slot_scheduler.
// Scenario tasks with a grant/done event scoreboard.
module tb_rate_slot_scheduler;

  localparam int W = 11;

  logic ClockIn = 1'b0;
  logic Reset   = 1'b1;

  rate_slot_scheduler_if #(.DIV_WIDTH(W)) bus ();

  rate_slot_scheduler #(
    .DIV_WIDTH (W),
    .LOAD_1    (500),
    .LOAD_2    (1000),
    .LOAD_3    (2000)
  ) dut (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .bus     (bus.slave)
  );

  always #5 ClockIn = ~ClockIn;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_ev[$];
  logic [4:0] obs_ev[$];
  logic [4:0] e, g;
  logic [3:0] prev_g = '0;
  logic [3:0] eg;
  int         n;

  // advance one cycle and log grant-rise / done events
  task automatic tick();
    @(posedge ClockIn);
    #1;
    if (bus.Grant != 4'b0 && bus.Grant != prev_g)
      obs_ev.push_back({1'b0, bus.Grant});
    if (bus.Done != 4'b0)
      obs_ev.push_back({1'b1, bus.Done});
    prev_g = bus.Grant;
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    bus.Req   = '0;
    bus.Speed = '0;
    tick();
    Reset = 1'b0;
    exp_ev.delete();
    obs_ev.delete();
  endtask

  task automatic test_reset();
    bus.Req   = '0;
    bus.Speed = '0;
    #2;
    checks += 4;
    if (bus.Grant !== 4'b0) begin
      errors++; $display("FAIL rst_grant: got %b want 0000", bus.Grant);
    end
    if (bus.Done !== 4'b0) begin
      errors++; $display("FAIL rst_done: got %b want 0000", bus.Done);
    end
    if (bus.Busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy: got %b want 0", bus.Busy);
    end
    if (bus.Remaining !== W'(0)) begin
      errors++; $display("FAIL rst_rem: got %0d want 0", bus.Remaining);
    end
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.Req   = 4'b0001;
    bus.Speed = 8'b0000_0001;
    exp_ev.push_back(5'b0_0001);
    exp_ev.push_back(5'b1_0001);
    tick();
    checks++;
    if (bus.Grant !== 4'b0001 || bus.Busy !== 1'b1 ||
        bus.Remaining !== W'(499)) begin
      errors++;
      $display("FAIL single_start: got g=%b b=%b r=%0d want g=0001 b=1 r=499",
               bus.Grant, bus.Busy, bus.Remaining);
    end
    for (int k = 1; k <= 499; k++) begin
      tick();
      checks++;
      if (bus.Grant !== 4'b0001 || bus.Busy !== 1'b1 ||
          bus.Remaining !== W'(499 - k)) begin
        errors++;
        $display("FAIL single_cnt: got g=%b r=%0d want g=0001 r=%0d",
                 bus.Grant, bus.Remaining, 499 - k);
      end
    end
    tick();
    checks++;
    if (bus.Done !== 4'b0001 || bus.Grant !== 4'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got d=%b g=%b b=%b want d=0001 g=0000 b=0",
               bus.Done, bus.Grant, bus.Busy);
    end
    bus.Req = '0;
    tick();
    checks++;
    if (bus.Done !== 4'b0) begin
      errors++; $display("FAIL single_pulse: got d=%b want 0000", bus.Done);
    end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      if (obs_ev.size() > 0) g = obs_ev.pop_front();
      else g = 5'h1f;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL single_ev: got %b want %b", g, e);
      end
    end
    checks++;
    if (obs_ev.size() != 0) begin
      errors++;
      $display("FAIL single_extra: got %0d extra events want 0", obs_ev.size());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.Req   = 4'b1111;
    bus.Speed = 8'h00;
    for (int i = 0; i < 5; i++) begin
      eg = 4'b0001 << (i % 4);
      exp_ev.push_back({1'b0, eg});
      exp_ev.push_back({1'b1, eg});
    end
    for (int c = 1; c <= 10; c++) begin
      tick();
      eg = (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0;
      checks++;
      if (bus.Grant !== eg) begin
        errors++;
        $display("FAIL rr_grant c%0d: got %b want %b", c, bus.Grant, eg);
      end
    end
    bus.Req = '0;
    tick();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      if (obs_ev.size() > 0) g = obs_ev.pop_front();
      else g = 5'h1f;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL rr_ev: got %b want %b", g, e);
      end
    end
    checks++;
    if (obs_ev.size() != 0) begin
      errors++;
      $display("FAIL rr_extra: got %0d extra events want 0", obs_ev.size());
    end
  endtask

  task automatic test_speed_sampled();
    do_reset();
    bus.Req   = 4'b0100;
    bus.Speed = 8'b0011_0000;
    exp_ev.push_back(5'b0_0100);
    exp_ev.push_back(5'b1_0100);
    tick();
    n = 0;
    while (bus.Grant === 4'b0100 && n < 3000) begin
      n++;
      if (n == 100) bus.Speed[5:4] = 2'b01;
      tick();
    end
    checks += 2;
    if (n != 2000) begin
      errors++; $display("FAIL spd_len: got %0d cycles want 2000", n);
    end
    if (bus.Done !== 4'b0100) begin
      errors++; $display("FAIL spd_done: got %b want 0100", bus.Done);
    end
    bus.Req = '0;
    tick();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      if (obs_ev.size() > 0) g = obs_ev.pop_front();
      else g = 5'h1f;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL spd_ev: got %b want %b", g, e);
      end
    end
    checks++;
    if (obs_ev.size() != 0) begin
      errors++;
      $display("FAIL spd_extra: got %0d extra events want 0", obs_ev.size());
    end
  endtask

  task automatic test_abort();
    do_reset();
    bus.Req   = 4'b1010;
    bus.Speed = 8'b0000_1000;
    exp_ev.push_back(5'b0_0010);
    exp_ev.push_back(5'b0_1000);
    exp_ev.push_back(5'b1_1000);
    tick();
    checks++;
    if (bus.Grant !== 4'b0010 || bus.Remaining !== W'(999)) begin
      errors++;
      $display("FAIL abort_start: got g=%b r=%0d want g=0010 r=999",
               bus.Grant, bus.Remaining);
    end
    n = 0;
    while (bus.Remaining !== W'(600) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (bus.Remaining !== W'(600)) begin
      errors++; $display("FAIL abort_reach: got r=%0d want 600", bus.Remaining);
    end
    bus.Req = 4'b1000;
    tick();
    checks++;
    if (bus.Grant !== 4'b0 || bus.Remaining !== W'(0) ||
        bus.Done !== 4'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got g=%b r=%0d d=%b b=%b want 0 0 0 0",
               bus.Grant, bus.Remaining, bus.Done, bus.Busy);
    end
    tick();
    checks++;
    if (bus.Grant !== 4'b1000 || bus.Remaining !== W'(0)) begin
      errors++;
      $display("FAIL abort_next: got g=%b r=%0d want g=1000 r=0",
               bus.Grant, bus.Remaining);
    end
    tick();
    bus.Req = '0;
    tick();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      if (obs_ev.size() > 0) g = obs_ev.pop_front();
      else g = 5'h1f;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL abort_ev: got %b want %b", g, e);
      end
    end
    checks++;
    if (obs_ev.size() != 0) begin
      errors++;
      $display("FAIL abort_extra: got %0d extra events want 0", obs_ev.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.Req   = 4'b0001;
    bus.Speed = 8'b0000_0011;
    exp_ev.push_back(5'b0_0001);
    exp_ev.push_back(5'b0_0001);
    tick();
    n = 0;
    while (bus.Remaining !== W'(1234) && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (bus.Remaining !== W'(1234)) begin
      errors++; $display("FAIL rmid_reach: got r=%0d want 1234", bus.Remaining);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.Grant !== 4'b0 || bus.Done !== 4'b0 ||
        bus.Busy !== 1'b0 || bus.Remaining !== W'(0)) begin
      errors++;
      $display("FAIL rmid_async: got g=%b d=%b b=%b r=%0d want all 0",
               bus.Grant, bus.Done, bus.Busy, bus.Remaining);
    end
    bus.Req = 4'b0011;
    tick();
    checks++;
    if (bus.Grant !== 4'b0) begin
      errors++; $display("FAIL rmid_hold: got g=%b want 0000", bus.Grant);
    end
    Reset = 1'b0;
    tick();
    checks++;
    if (bus.Grant !== 4'b0001 || bus.Remaining !== W'(1999)) begin
      errors++;
      $display("FAIL rmid_regrant: got g=%b r=%0d want g=0001 r=1999",
               bus.Grant, bus.Remaining);
    end
    bus.Req = '0;
    tick();
    tick();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      if (obs_ev.size() > 0) g = obs_ev.pop_front();
      else g = 5'h1f;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL rmid_ev: got %b want %b", g, e);
      end
    end
    checks++;
    if (obs_ev.size() != 0) begin
      errors++;
      $display("FAIL rmid_extra: got %0d extra events want 0", obs_ev.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.Req   = 4'b0100;
    bus.Speed = 8'h00;
    exp_ev.push_back(5'b0_0100);
    exp_ev.push_back(5'b1_0100);
    exp_ev.push_back(5'b0_0001);
    exp_ev.push_back(5'b1_0001);
    exp_ev.push_back(5'b0_0100);
    exp_ev.push_back(5'b1_0100);
    tick();
    bus.Req = 4'b0101;
    tick();
    tick();
    checks++;
    if (bus.Grant !== 4'b0001) begin
      errors++; $display("FAIL wrap_first: got g=%b want 0001", bus.Grant);
    end
    tick();
    tick();
    checks++;
    if (bus.Grant !== 4'b0100) begin
      errors++; $display("FAIL wrap_second: got g=%b want 0100", bus.Grant);
    end
    tick();
    bus.Req = '0;
    tick();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      if (obs_ev.size() > 0) g = obs_ev.pop_front();
      else g = 5'h1f;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL wrap_ev: got %b want %b", g, e);
      end
    end
    checks++;
    if (obs_ev.size() != 0) begin
      errors++;
      $display("FAIL wrap_extra: got %0d extra events want 0", obs_ev.size());
    end
  endtask

  initial begin
    bus.Req   = '0;
    bus.Speed = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_speed_sampled();
    test_abort();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
